// File: rtl/pwm_duty_sequencer.sv
// Steps a PWM generator's duty level toward a commanded target by issuing
// fixed-width increase/decrease pulses separated by idle gaps.
module pwm_duty_sequencer #(
    parameter int HOLD_CYC    = 4,
    parameter int GAP_CYC     = 4,
    parameter int MAX_LEVEL   = 10,
    parameter int RESET_LEVEL = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_target,
    output logic       cmd_ready,
    input  logic       abort,
    output logic       increase_duty,
    output logic       decrease_duty,
    output logic [3:0] duty_level,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYC - 1);
    localparam logic [3:0]       MAX_L     = 4'(MAX_LEVEL);
    localparam logic [3:0]       RST_L     = 4'(RESET_LEVEL);

    function automatic logic [3:0] clip_level(input logic [3:0] t);
        return (t > MAX_L) ? MAX_L : t;
    endfunction

    function automatic logic [3:0] step_level(input logic [3:0] lvl, input logic up);
        if (up)
            return (lvl >= MAX_L) ? MAX_L : lvl + 4'd1;
        else
            return (lvl == 4'd0) ? 4'd0 : lvl - 4'd1;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       level_q, level_d;
    logic [3:0]       target_q, target_d;
    logic             up_q, up_d;
    logic             abort_q, abort_d;
    logic             inc_q, inc_d;
    logic             dec_q, dec_d;
    logic             done_q, done_d;
    logic [3:0]       cmd_tgt_clip;

    assign cmd_tgt_clip = clip_level(cmd_target);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        target_d = target_q;
        up_d     = up_q;
        abort_d  = abort_q;
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (cmd_valid) begin
                    target_d = cmd_tgt_clip;
                    if (cmd_tgt_clip == level_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ASSERT;
                        up_d    = cmd_tgt_clip > level_q;
                        cnt_d   = HOLD_LOAD;
                        inc_d   = cmd_tgt_clip > level_q;
                        dec_d   = !(cmd_tgt_clip > level_q);
                    end
                end
            end
            ASSERT: begin
                if (abort)
                    abort_d = 1'b1;
                if (cnt_q == '0) begin
                    // The step is only counted once the pulse has been held in full.
                    level_d = step_level(level_q, up_q);
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    inc_d = up_q;
                    dec_d = !up_q;
                end
            end
            GAP: begin
                if (abort)
                    abort_d = 1'b1;
                if (cnt_q == '0) begin
                    if (level_q == target_q || abort_q || abort) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ASSERT;
                        cnt_d   = HOLD_LOAD;
                        inc_d   = up_q;
                        dec_d   = !up_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                abort_d = 1'b0;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            level_q  <= RST_L;
            target_q <= '0;
            up_q     <= 1'b0;
            abort_q  <= 1'b0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            target_q <= target_d;
            up_q     <= up_d;
            abort_q  <= abort_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            done_q   <= done_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign increase_duty = inc_q;
    assign decrease_duty = dec_q;
    assign duty_level    = level_q;
    assign done          = done_q;

endmodule

// File: doc/pwm_duty_sequencer.md
PWM_DUTY_SEQUENCER -- requirements
Module: pwm_duty_sequencer

Interface
REQ-001 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-002 Parameter: HOLD_CYC, 4, cycles each increase_duty/decrease_duty pulse is held high.
REQ-003 Parameter: GAP_CYC, 4, cycles both step outputs are held low between pulses.
REQ-004 Parameter: MAX_LEVEL, 10, highest duty level (10% per level).
REQ-005 Parameter: RESET_LEVEL, 5, duty level the PWM generator holds after reset.
REQ-006 Port: clk  input  1  system clock, rising edge.
REQ-007 Port: rst  input  1  synchronous active-high reset.
REQ-008 Port: cmd_valid  input  1  new target duty level offered.
REQ-009 Port: cmd_target  input  4  requested duty level, 0..15.
REQ-010 Port: cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-011 Port: abort  input  1  stop the ramp at the next step boundary.
REQ-012 Port: increase_duty  output  1  step-up pulse to the PWM generator.
REQ-013 Port: decrease_duty  output  1  step-down pulse to the PWM generator.
REQ-014 Port: duty_level  output  4  tracked generator duty level.
REQ-015 Port: busy  output  1  high in any state other than IDLE.
REQ-016 Port: done  output  1  one-cycle pulse when a command completes.

Function
REQ-017 States SHALL be IDLE, ASSERT, GAP and DONE; cmd_ready = (state == IDLE).
REQ-018 On accept, the target SHALL be latched as min(cmd_target, MAX_LEVEL).
- If the latched target equals duty_level, the next state SHALL be DONE and no pulses are issued.
- Otherwise the next state SHALL be ASSERT, with direction up if target > duty_level, else down.
REQ-019 ASSERT SHALL drive the selected step output high for exactly HOLD_CYC cycles.
- The first high cycle is the cycle after accept.
- On the last ASSERT cycle, duty_level SHALL change by +/-1, taking effect the following cycle, and the next state SHALL be GAP.
REQ-020 GAP SHALL hold both step outputs low for exactly GAP_CYC cycles, then:
- go to DONE if duty_level equals the target or an abort is pending;
- otherwise go to ASSERT.
REQ-021 DONE SHALL last one cycle with done = 1, then return to IDLE.
REQ-022 increase_duty and decrease_duty SHALL never be high in the same cycle, and SHALL be low outside ASSERT.
REQ-023 cmd_valid SHALL be ignored while busy; commands are not queued.
REQ-024 abort:
- In IDLE or DONE, abort SHALL have no effect.
- In ASSERT, abort SHALL set a pending flag; the current pulse completes its full HOLD_CYC cycles, then GAP, then DONE.
- In GAP, abort SHALL set the pending flag and exit to DONE when GAP ends.
- The pending flag SHALL clear on entry to IDLE.
REQ-025 duty_level SHALL saturate within 0..MAX_LEVEL and never wrap.
REQ-026 The hold/gap counter SHALL be wide enough for max(HOLD_CYC, GAP_CYC) and SHALL reload on every state entry.

Reset
REQ-027 While rst is high, the block SHALL set on the next edge:
- state to IDLE and duty_level to RESET_LEVEL;
- increase_duty, decrease_duty, busy and done to 0, and cmd_ready to 1;
- the abort flag and counters to 0.
REQ-028 Reset during ASSERT SHALL drop the step output on the next edge; the partial step SHALL NOT be counted.

Verification (defaults; accept at cycle 0)
REQ-029 Reset released -> duty_level = 5, cmd_ready = 1, all step outputs 0.
REQ-030 Target 8 -> increase_duty high cycles 1-4, 9-12 and 17-20; done at cycle 25; duty_level = 8; decrease_duty never high.
REQ-031 Target 15 from level 8 -> two up pulses; final duty_level = 10.
REQ-032 Target equal to duty_level -> done at cycle 1, no pulses, cmd_ready back to 1 at cycle 2.
REQ-033 Target 0 from level 5, abort asserted at cycle 10 -> second decrease pulse (cycles 9-12) completes, then GAP, then done; duty_level = 3.
REQ-034 rst asserted at cycle 2 of a ramp, plus cmd_valid pulsed at cycle 3 of any ramp -> after rst, step outputs 0 and duty_level = 5; the cmd_valid pulse while busy is ignored.
